fetch_unit: RTL

//  RV64 instruction fetch stage plus IF/ID pipeline register. Holds the PC, issues
//  one-outstanding requests to instruction memory, and presents {pc, instr} to the

---
 rtl/rv_pkg.sv | 23 ++
 rtl/fetch_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV64 core types and constants
// Contents: XLEN, NOP_INSTR, RESET_PC, fetch_state_t, if_id_t.
package rv_pkg;

  localparam int          XLEN      = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [63:0] RESET_PC  = 64'h0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    KILL = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV64 instruction fetch stage with IF/ID register
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   imem_req_valid/ready, imem_addr     fetch request (one outstanding)
//   imem_rsp_valid, imem_rsp_data       instruction return
//   redirect_valid, redirect_pc         taken branch/jump: flush and refetch
//   id_stall                            decode back-pressure, holds IF/ID
//   if_id_valid, if_id_pc, if_id_instr  IF/ID register to decode
module fetch_unit
  import rv_pkg::*;
#(
  parameter int          XLEN     = rv_pkg::XLEN,
  parameter logic [63:0] RESET_PC = rv_pkg::RESET_PC,
  parameter logic [31:0] NOP      = rv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] req_pc, req_pc_n;
  if_id_t          if_id, if_id_n;
  if_id_t          buf_q, buf_n;   // buf_q.valid doubles as buf_valid

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC[XLEN-1:0];
      req_pc <= '0;
      if_id  <= '{valid: 1'b0, pc: '0, instr: NOP};
      buf_q  <= '{valid: 1'b0, pc: '0, instr: NOP};
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      req_pc <= req_pc_n;
      if_id  <= if_id_n;
      buf_q  <= buf_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    req_pc_n = req_pc;
    if_id_n  = if_id;
    buf_n    = buf_q;

    // Decode took the current instruction; any load below overrides this.
    if (if_id.valid && !id_stall) begin
      if_id_n.valid = 1'b0;
      if_id_n.instr = NOP;
    end

    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (imem_req_ready) begin
          req_pc_n = pc;
          pc_n     = pc + XLEN'(4);
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (!if_id.valid || !id_stall) begin
            if_id_n = '{valid: 1'b1, pc: req_pc, instr: imem_rsp_data};
            state_n = REQ;
          end else begin
            // IF/ID is full and held: park the word so the bus is free.
            buf_n   = '{valid: 1'b1, pc: req_pc, instr: imem_rsp_data};
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (!id_stall) begin
          if_id_n       = buf_q;
          if_id_n.valid = 1'b1;
          buf_n.valid   = 1'b0;
          state_n       = REQ;
        end
      end
      KILL: begin
        if (imem_rsp_valid) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase

    // Redirect wins over everything; a response still owed must be drained in KILL.
    if (redirect_valid && state != IDLE) begin
      pc_n          = {redirect_pc[XLEN-1:2], 2'b00};
      if_id_n.valid = 1'b0;
      if_id_n.instr = NOP;
      buf_n.valid   = 1'b0;
      case (state)
        REQ:     state_n = imem_req_ready ? KILL : REQ;
        WAIT:    state_n = imem_rsp_valid ? REQ : KILL;
        HOLD:    state_n = REQ;
        KILL:    state_n = KILL;
        default: state_n = REQ;
      endcase
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc;
  assign if_id_valid    = if_id.valid;
  assign if_id_pc       = if_id.pc;
  assign if_id_instr    = if_id.instr;

endmodule
